// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage.
//   MD_*  : result-select encodings carried down from EX (3 falls back to fout)
//   ST_*  : bit positions inside the {V,C,N,Z} status register
package wb_pkg;

    localparam logic [1:0] MD_FOUT = 2'd0;
    localparam logic [1:0] MD_MEM  = 2'd1;
    localparam logic [1:0] MD_LINK = 2'd2;

    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, asynchronous clear. With R0_ZERO, register 0 reads as zero and
// writes to it are discarded. Write-through bypass lives in the caller.
//   clk, rst_n        : clock / async active-low clear
//   we, wa, wd        : write enable, address, data
//   ra_addr, rb_addr  : read addresses
//   ra_data, rb_data  : read data (array contents, no bypass)
module register_file #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && !(R0_ZERO && wa == '0)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (R0_ZERO && ra_addr == '0) ? '0 : regs[ra_addr];
    assign rb_data = (R0_ZERO && rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/inst_writeback.sv
// Writeback stage: EX/WB pipeline register, result select (fout / memory /
// link), register-file commit, status load, retired counter, and decode read
// ports with write-through bypass.
//   clk, rst_n                 : clock / async active-low reset
//   stall                      : hold the WB entry, no commit
//   ex_*                       : fields captured from execute
//   memout                     : synchronous data-memory output
//   ra_addr/rb_addr -> *_data  : decode read ports (bypassed)
//   wb_valid, wb_we, wb_rd, wb_data : WB entry state, also used for EX forwarding
//   status                     : {V,C,N,Z}
//   retired                    : committed-instruction count (wraps)
module inst_writeback
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rw,
    input  logic [1:0]        ex_md,
    input  logic              ex_fl,
    input  logic [DATA_W-1:0] ex_fout,
    input  logic [DATA_W-1:0] ex_link,
    input  logic              ex_overflow,
    input  logic              ex_carryout,
    input  logic              ex_negative,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] memout,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        status,
    output logic [31:0]       retired
);

    logic              rw_q, fl_q, first;
    logic [1:0]        md_q;
    logic [DATA_W-1:0] fout_q, link_q, ld_q, mem_sel;
    logic [3:0]        flags_q;
    logic              commit;
    logic [DATA_W-1:0] rf_a, rf_b;

    // EX/WB register. "first" marks the entry's first WB cycle, the only
    // cycle in which the synchronous memory output belongs to this entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            rw_q     <= 1'b0;
            md_q     <= '0;
            fl_q     <= 1'b0;
            fout_q   <= '0;
            link_q   <= '0;
            flags_q  <= '0;
            first    <= 1'b0;
            ld_q     <= '0;
        end else begin
            if (first) ld_q <= memout;
            if (!stall) begin
                wb_valid <= ex_valid;
                wb_rd    <= ex_rd;
                rw_q     <= ex_rw;
                md_q     <= ex_md;
                fl_q     <= ex_fl;
                fout_q   <= ex_fout;
                link_q   <= ex_link;
                flags_q[ST_V] <= ex_overflow;
                flags_q[ST_C] <= ex_carryout;
                flags_q[ST_N] <= ex_negative;
                flags_q[ST_Z] <= ex_zero;
                first    <= 1'b1;
            end else begin
                first    <= 1'b0;
            end
        end
    end

    // Live memout only in the first cycle; stalled cycles replay the capture.
    assign mem_sel = first ? memout : ld_q;

    always_comb begin
        wb_data = fout_q;
        case (md_q)
            MD_MEM:  wb_data = mem_sel;
            MD_LINK: wb_data = link_q;
            default: wb_data = fout_q;
        endcase
    end

    assign commit = wb_valid && !stall;
    assign wb_we  = commit && rw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status  <= '0;
            retired <= '0;
        end else if (commit) begin
            if (fl_q) status <= flags_q;
            retired <= retired + 32'd1;
        end
    end

    register_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .R0_ZERO(R0_ZERO)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_we),
        .wa     (wb_rd),
        .wd     (wb_data),
        .ra_addr(ra_addr),
        .rb_addr(rb_addr),
        .ra_data(rf_a),
        .rb_data(rf_b)
    );

    // R0 wins over bypass so a discarded r0 write never leaks to decode.
    always_comb begin
        ra_data = rf_a;
        rb_data = rf_b;
        if (R0_ZERO && ra_addr == '0)        ra_data = '0;
        else if (wb_we && ra_addr == wb_rd)  ra_data = wb_data;
        if (R0_ZERO && rb_addr == '0)        rb_data = '0;
        else if (wb_we && rb_addr == wb_rd)  rb_data = wb_data;
    end

endmodule

// File: tb/tb_inst_writeback.sv
module tb_inst_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_rw;
    logic [1:0]  ex_md;
    logic        ex_fl;
    logic [31:0] ex_fout, ex_link;
    logic        ex_overflow, ex_carryout, ex_negative, ex_zero;
    logic [31:0] memout;
    logic [4:0]  ra_addr, rb_addr;
    logic [31:0] ra_data, rb_data;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  status;
    logic [31:0] retired;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    inst_writeback #(.DATA_W(32), .REG_AW(5), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_md(ex_md),
        .ex_fl(ex_fl), .ex_fout(ex_fout), .ex_link(ex_link),
        .ex_overflow(ex_overflow), .ex_carryout(ex_carryout),
        .ex_negative(ex_negative), .ex_zero(ex_zero),
        .memout(memout), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .status(status), .retired(retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance past a rising edge; inputs are changed and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic [4:0] rd, input logic rw,
                          input logic [1:0] md, input logic fl,
                          input logic [31:0] fout, input logic [31:0] link,
                          input logic [3:0] vcnz);
        ex_valid = v; ex_rd = rd; ex_rw = rw; ex_md = md; ex_fl = fl;
        ex_fout = fout; ex_link = link;
        {ex_overflow, ex_carryout, ex_negative, ex_zero} = vcnz;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; memout = '0; ra_addr = '0; rb_addr = '0;
        ex_set(1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 4'h0);
        #12;
        ra_addr = 5'd5;
        #1;
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_status",   {28'b0, status},   32'd0);
        chk("rst_retired",  retired,           32'd0);
        chk("rst_r5",       ra_data,           32'd0);
        @(negedge clk); rst_n = 1'b1;

        // ALU commit
        @(negedge clk);
        ex_set(1'b1, 5'd5, 1'b1, 2'd0, 1'b0, 32'h0000_1234, 32'h0, 4'h0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("alu_we",     {31'b0, wb_we}, 32'd1);
        chk("alu_data",   wb_data,        32'h0000_1234);
        chk("alu_rd",     {27'b0, wb_rd}, 32'd5);
        chk("alu_bypass", ra_data,        32'h0000_1234);
        tick();
        chk("alu_r5",      ra_data,          32'h0000_1234);
        chk("alu_retired", retired,          32'd1);
        chk("alu_bubble",  {31'b0, wb_valid}, 32'd0);

        // Load held for three stalled cycles; memout goes stale after the first
        ex_set(1'b1, 5'd7, 1'b1, 2'd1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        ex_valid = 1'b0; stall = 1'b1; memout = 32'hDEAD_BEEF; ra_addr = 5'd7;
        #1;
        chk("ld_we_s1",   {31'b0, wb_we}, 32'd0);
        chk("ld_data_s1", wb_data,        32'hDEAD_BEEF);
        tick();
        memout = 32'h0;
        #1;
        chk("ld_we_s2",   {31'b0, wb_we}, 32'd0);
        chk("ld_data_s2", wb_data,        32'hDEAD_BEEF);
        tick();
        chk("ld_we_s3",   {31'b0, wb_we}, 32'd0);
        chk("ld_r7_held", ra_data,        32'd0);
        tick();
        stall = 1'b0;
        #1;
        chk("ld_we_go",   {31'b0, wb_we}, 32'd1);
        chk("ld_data_go", wb_data,        32'hDEAD_BEEF);
        tick();
        chk("ld_r7",      ra_data,        32'hDEAD_BEEF);
        chk("ld_retired", retired,        32'd2);

        // Bypass on both ports
        ex_set(1'b1, 5'd3, 1'b1, 2'd0, 1'b0, 32'hA5A5_A5A5, 32'h0, 4'h0);
        tick();
        ex_valid = 1'b0; ra_addr = 5'd3; rb_addr = 5'd3;
        #1;
        chk("byp_a", ra_data, 32'hA5A5_A5A5);
        chk("byp_b", rb_data, 32'hA5A5_A5A5);
        tick();

        // Write to r0 is discarded, bypass included
        ex_set(1'b1, 5'd0, 1'b1, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0);
        tick();
        ex_valid = 1'b0; ra_addr = 5'd0; rb_addr = 5'd3;
        #1;
        chk("r0_bypass", ra_data, 32'd0);
        tick();
        chk("r0_after",   ra_data, 32'd0);
        chk("r3_kept",    rb_data, 32'hA5A5_A5A5);
        chk("r0_retired", retired, 32'd4);

        // Flags load, then a non-loading instruction leaves status alone
        ex_set(1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0, 4'b1010);
        tick();
        ex_set(1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 4'b0101);
        tick();
        chk("fl_load", {28'b0, status}, 32'hA);
        ex_valid = 1'b0;
        tick();
        chk("fl_hold",    {28'b0, status}, 32'hA);
        chk("fl_retired", retired,         32'd6);

        // Bubble with rw set must not write or count
        ex_set(1'b0, 5'd9, 1'b1, 2'd0, 1'b0, 32'h77, 32'h0, 4'h0);
        ra_addr = 5'd9;
        tick();
        chk("bub_we", {31'b0, wb_we}, 32'd0);
        tick();
        chk("bub_r9",      ra_data, 32'd0);
        chk("bub_retired", retired, 32'd6);

        // Link select
        ex_set(1'b1, 5'd31, 1'b1, 2'd2, 1'b0, 32'h99, 32'h0000_0040, 4'h0);
        ra_addr = 5'd31;
        tick();
        ex_valid = 1'b0;
        tick();
        chk("link_r31",     ra_data, 32'h0000_0040);
        chk("link_retired", retired, 32'd7);

        // Reset while a flag-loading load is stalled in WB
        ex_set(1'b1, 5'd7, 1'b1, 2'd1, 1'b1, 32'h0, 32'h0, 4'b1111);
        tick();
        ex_valid = 1'b0; stall = 1'b1; memout = 32'h1234_5678;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid",   {31'b0, wb_valid}, 32'd0);
        chk("mrst_status",  {28'b0, status},   32'd0);
        chk("mrst_retired", retired,           32'd0);
        chk("mrst_r7",      ra_data,           32'd0);
        @(negedge clk); @(negedge clk);
        stall = 1'b0; rst_n = 1'b1;
        tick();
        chk("post_r7",     ra_data,          32'd0);
        chk("post_valid",  {31'b0, wb_valid}, 32'd0);
        chk("post_status", {28'b0, status},   32'd0);

        // Counter wrap
        @(negedge clk);
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        ex_set(1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        ex_valid = 1'b0;
        chk("wrap_pre",  retired, 32'hFFFF_FFFF);
        tick();
        chk("wrap_zero", retired, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
